// File: rtl/rv_pkg.sv
// Shared register-file types and sizes for the writeback path.
// Included by the arbiter, scoreboard and issue-side logic.
package rv_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int MAX_DATA_W = 64;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      logic                  valid;
      reg_addr_t             rd;
      logic [MAX_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// The pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N-1:0]              i_req,
   output logic [N-1:0]              o_gnt,
   output logic                      o_any,
   output logic [$clog2(N)-1:0]      o_idx
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic          w_found;
   logic [N-1:0]  w_gnt;

   always_comb begin
      int j;
      j       = 0;
      w_found = 1'b0;
      w_idx   = '0;
      w_gnt   = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(r_ptr) + k;
         if (j >= N) j = j - N;
         if (!w_found && i_req[j]) begin
            w_found = 1'b1;
            w_idx   = PW'(j);
         end
      end
      // Grants are masked during reset so nothing is consumed.
      if (w_found && rst_n) w_gnt[w_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= (w_idx == PW'(N-1)) ? '0 : w_idx + 1'b1;
      end
   end

   assign o_gnt = w_gnt;
   assign o_any = w_found & rst_n;
   assign o_idx = w_idx;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between writeback units and
// tracks pending destination writes for hazard checks at issue.
module regfile_wb_arbiter
   import rv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_REQ = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*5-1:0]     req_rd,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   wb_we,
   output logic [4:0]             wb_ad,
   output logic [WIDTH-1:0]       wb_wd,
   input  logic                   issue_valid,
   input  logic [4:0]             issue_rd,
   output logic                   issue_ready,
   input  logic [4:0]             rs1_addr,
   input  logic [4:0]             rs2_addr,
   output logic                   rs1_busy,
   output logic                   rs2_busy,
   output logic [31:0]            busy_vec
);

   localparam int PW = $clog2(N_REQ);

   wb_req_t             w_req [N_REQ];
   wb_req_t             w_sel;
   logic [N_REQ-1:0]    w_gnt;
   logic                w_any;
   logic [PW-1:0]       w_idx;

   logic                r_we;
   reg_addr_t           r_ad;
   logic [WIDTH-1:0]    r_wd;
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_alloc;

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign w_req[i].valid = req_valid[i];
      assign w_req[i].rd    = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
      assign w_req[i].data  = MAX_DATA_W'(req_data[i*WIDTH +: WIDTH]);
   end

   rr_arbiter #(
      .N (N_REQ)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (req_valid),
      .o_gnt (w_gnt),
      .o_any (w_any),
      .o_idx (w_idx)
   );

   assign w_sel     = w_req[w_idx];
   assign req_ready = w_gnt;

   // x0 writes are consumed but never reach the register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we <= 1'b0;
         r_ad <= '0;
         r_wd <= '0;
      end else if (w_any) begin
         r_we <= (w_sel.rd != '0);
         r_ad <= w_sel.rd;
         r_wd <= w_sel.data[WIDTH-1:0];
      end else begin
         r_we <= 1'b0;
      end
   end

   assign issue_ready = issue_valid &&
                        (issue_rd == '0 || !r_busy[issue_rd]);
   assign w_alloc     = issue_ready && (issue_rd != '0);

   always_comb begin
      w_busy_nxt = r_busy;
      if (r_we)    w_busy_nxt[r_ad]     = 1'b0;
      if (w_alloc) w_busy_nxt[issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign rs1_busy = r_busy[rs1_addr];
   assign rs2_busy = r_busy[rs2_addr];
   assign busy_vec = r_busy;

   assign wb_we = r_we;
   assign wb_ad = r_ad;
   assign wb_wd = r_wd;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised bench for regfile_wb_arbiter against an array-based model.
module tb_regfile_wb_arbiter;

   localparam int W = 32;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*5-1:0] req_rd;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           wb_we;
   logic [4:0]     wb_ad;
   logic [W-1:0]   wb_wd;
   logic           issue_valid;
   logic [4:0]     issue_rd;
   logic           issue_ready;
   logic [4:0]     rs1_addr;
   logic [4:0]     rs2_addr;
   logic           rs1_busy;
   logic           rs2_busy;
   logic [31:0]    busy_vec;

   regfile_wb_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_rd      (req_rd),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .wb_we       (wb_we),
      .wb_ad       (wb_ad),
      .wb_wd       (wb_wd),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .busy_vec    (busy_vec)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   logic        tv_valid [N];
   logic [4:0]  tv_rd    [N];
   logic [31:0] tv_data  [N];
   bit          m_hold   [N];

   int          m_ptr;
   bit          m_busy [32];
   bit          m_we;
   logic [4:0]  m_ad;
   logic [31:0] m_wd;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = tv_valid[i];
         req_rd[i*5 +: 5]    = tv_rd[i];
         req_data[i*W +: W]  = tv_data[i];
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_we  = 0;
      m_ad  = '0;
      m_wd  = '0;
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         tv_valid[i] = 0;
         tv_rd[i]    = '0;
         tv_data[i]  = '0;
         m_hold[i]   = 0;
      end
   endtask

   // One cycle: inputs are already set just after a falling edge.
   task automatic cycle();
      int          g;
      int          idx;
      logic [N-1:0] eg;
      logic [31:0] eb;
      bit          eir;
      apply();
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (g < 0 && tv_valid[idx]) g = idx;
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      for (int r = 0; r < 32; r++) eb[r] = m_busy[r];
      eir = issue_valid && (issue_rd == 0 || !m_busy[issue_rd]);
      chk("req_ready", 64'(req_ready), 64'(eg));
      chk("issue_ready", 64'(issue_ready), 64'(eir));
      chk("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr]));
      chk("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr]));
      chk("busy_vec", 64'(busy_vec), 64'(eb));
      chk("wb_we", 64'(wb_we), 64'(m_we));
      chk("wb_ad", 64'(wb_ad), 64'(m_ad));
      chk("wb_wd", 64'(wb_wd), 64'(m_wd));
      if (m_we) m_busy[m_ad] = 0;
      if (eir && issue_rd != 0) m_busy[issue_rd] = 1;
      if (g >= 0) begin
         m_we  = (tv_rd[g] != 0);
         m_ad  = tv_rd[g];
         m_wd  = tv_data[g];
         m_ptr = (g + 1) % N;
         m_hold[g] = 0;
      end else begin
         m_we = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n       = 1'b0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      rs1_addr    = '0;
      rs2_addr    = '0;
      clear_reqs();
      for (int i = 0; i < N; i++) tv_valid[i] = 1;
      apply();
      #12;
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_we", 64'(wb_we), 64'(0));
      chk("rst_busy", 64'(busy_vec), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // round robin with all requesters continuously valid
      for (int i = 0; i < N; i++) begin
         tv_valid[i] = 1;
         tv_rd[i]    = 5'(5 + i);
         tv_data[i]  = 32'hA0 + 32'(i);
      end
      for (int c = 0; c < 7; c++) cycle();
      clear_reqs();

      // RAW hazard on x5
      issue_valid = 1; issue_rd = 5;
      cycle();
      rs1_addr = 5;
      cycle();
      issue_valid = 0;
      tv_valid[0] = 1; tv_rd[0] = 5; tv_data[0] = 32'h1234_5678;
      cycle();
      clear_reqs();
      cycle();
      issue_valid = 1; issue_rd = 5;
      cycle();
      issue_valid = 0;

      // x0 handling
      issue_valid = 1; issue_rd = 0;
      cycle();
      issue_valid = 0; rs1_addr = 0;
      tv_valid[1] = 1; tv_rd[1] = 0; tv_data[1] = 32'hDEAD_BEEF;
      cycle();
      clear_reqs();
      cycle();

      // concurrent clear of x3 and allocation of x9
      issue_valid = 1; issue_rd = 3;
      cycle();
      issue_valid = 0;
      tv_valid[2] = 1; tv_rd[2] = 3; tv_data[2] = 32'h33;
      cycle();
      clear_reqs();
      issue_valid = 1; issue_rd = 9; rs1_addr = 3; rs2_addr = 9;
      cycle();
      issue_valid = 0;
      cycle();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!m_hold[i]) begin
               tv_valid[i] = 1'($urandom % 2);
               tv_rd[i]    = 5'($urandom % 8);
               tv_data[i]  = $urandom;
               m_hold[i]   = tv_valid[i];
            end
         end
         issue_valid = 1'($urandom % 2);
         issue_rd    = 5'($urandom % 8);
         rs1_addr    = 5'($urandom % 8);
         rs2_addr    = 5'($urandom % 8);
         cycle();
      end

      // asynchronous reset with a write in flight
      clear_reqs();
      issue_valid = 1; issue_rd = 4;
      cycle();
      issue_valid = 0;
      tv_valid[0] = 1; tv_rd[0] = 9; tv_data[0] = 32'h99;
      cycle();
      chk("pre_we", 64'(wb_we), 64'(1));
      chk("pre_busy4", 64'(busy_vec[4]), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("async_we", 64'(wb_we), 64'(0));
      chk("async_busy", 64'(busy_vec), 64'(0));
      chk("async_ready", 64'(req_ready), 64'(0));
      clear_reqs();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 3; c++) cycle();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (address/enable/data) between N_REQ writeback requesters, e.g. ALU, load unit and mul/div unit.
- Uses round-robin arbitration with a valid/ready handshake.
- Holds a scoreboard with one pending-write bit per architectural register. Issue logic uses it to stall on read-after-write hazards and to block a second write to the same destination while one is outstanding.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- WIDTH, 32, data width of writeback values (matches register file width)
- N_REQ, 3, number of writeback requesters (2..8)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  requester i has a writeback pending
- req_rd  in  N_REQ*5  destination register of requester i (slice i = bits 5i+4:5i)
- req_data  in  N_REQ*WIDTH  writeback data of requester i (slice i)
- req_ready  out  N_REQ  one-hot grant; requester i is consumed this cycle
- wb_we  out  1  register file write enable (registered)
- wb_ad  out  5  register file write address (registered)
- wb_wd  out  WIDTH  register file write data (registered)
- issue_valid  in  1  issue stage wants to allocate a destination
- issue_rd  in  5  destination being allocated
- issue_ready  out  1  allocation accepted this cycle
- rs1_addr  in  5  source 1 lookup address
- rs2_addr  in  5  source 2 lookup address
- rs1_busy  out  1  source 1 has a pending write
- rs2_busy  out  1  source 2 has a pending write
- busy_vec  out  32  full scoreboard (debug/verification)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - wb_we=0, wb_ad=0, wb_wd=0
  - busy_vec=0
  - round-robin pointer ptr=0
  - req_ready=0 combinationally while rst_n=0
- Arbitration (combinational):
  - grant goes to the first i with req_valid[i], searching from ptr upward and wrapping modulo N_REQ.
  - req_ready = onehot(grant). At most one bit is set. req_ready is 0 when no request is valid.
  - A handshake is req_valid[i] && req_ready[i].
  - Requesters hold valid, rd and data stable until their handshake.
- Pointer update: on a handshake by i, ptr <= (i+1) mod N_REQ. With no handshake, ptr holds.
- Write port latency: one cycle. On the edge after a handshake by i:
  - wb_we <= (req_rd_i != 0)
  - wb_ad <= req_rd_i
  - wb_wd <= req_data_i
- With no handshake, wb_we <= 0 and wb_ad/wb_wd hold their previous values.
- Writes to x0 are consumed (req_ready pulses) but never assert wb_we.
- Scoreboard:
  - busy[0] is hardwired 0.
  - issue_ready = issue_valid && (issue_rd == 0 || !busy[issue_rd]).
  - Allocation: on an edge with issue_ready=1 and issue_rd!=0, busy[issue_rd] <= 1.
  - Clear: on an edge with wb_we=1, busy[wb_ad] <= 0. This is the same edge on which the register file commits the data, so a reader sees the new value once busy drops.
  - Simultaneous clear and allocation of the same register is impossible, because issue_ready is 0 while busy. Clear and allocation of different registers in the same cycle both take effect.
  - A writeback to a register whose busy bit is 0 is still performed and leaves busy at 0.
- Lookups: rs1_busy = busy[rs1_addr] and rs2_busy = busy[rs2_addr], both combinational. A lookup of x0 always returns 0.
- Mid-operation reset: all pending bits and the registered write are discarded immediately. No write is issued after rst_n deasserts until a new handshake occurs.

Decomposition:
- Shared package rv_pkg:
  - REG_ADDR_W=5 and NUM_REGS=32
  - typedef reg_addr_t = logic [REG_ADDR_W-1:0]
  - typedef wb_req_t = struct {valid, rd, data}
- Natural sub-module rr_arbiter #(N), containing the request vector, grant one-hot, handshake-driven pointer and asynchronous active-low reset. It is reusable for other shared ports.
- The scoreboard and write-port registers stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1. Expect req_ready=0, wb_we=0 and busy_vec=0. Release reset; requester 0 is granted first.
- Round-robin: hold all 3 req_valid=1 continuously with rd=5,6,7 and data=A,B,C. Grants are 0,1,2,0,… and wb_we=1 one cycle after each grant, with wb_ad 5,6,7 in sequence.
- Scoreboard hazard:
  - Issue rd=5, so busy[5]=1 and rs1_addr=5 gives rs1_busy=1.
  - A second issue of rd=5 sees issue_ready=0.
  - Writeback rd=5 clears busy[5] on the wb_we edge; the re-issue is then accepted.
- x0 handling: issuing rd=0 gives issue_ready=1 with busy_vec unchanged. Request rd=0 with data=0xDEADBEEF: req_ready pulses, wb_we stays 0 and rs1_addr=0 gives busy=0.
- Concurrent clear/allocate: in the same cycle, wb_we=1 with wb_ad=3 and an issue of rd=9. After the edge, busy[3]=0 and busy[9]=1.
- Reset mid-flight: with busy[4]=1 and a handshake just completed, assert rst_n=0 asynchronously. wb_we drops to 0 without waiting for a clock, and busy_vec=0.
